cpu_imm_unit: RTL and testbench

Pipelined, parametrised immediate generator for the pipelined core's decode stage. It takes a full 32-bit instruction, an immediate-format select and a sideband tag. One cycle later it returns the XLEN-wide extended immediate, the tag and an illegal-format flag. Upstream and downstream connect through valid/ready handshakes with a 2-entry skid buffer, so the unit sustains 1 instruction per cycle under backpressure. It adds XLEN=64 support, the CSR zimm and shift-amount formats, illegal-format detection and a pipeline flush.

---
 rtl/cpu_imm_unit.sv | 147 ++++++++++++++
 tb/tb_cpu_imm_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_imm_unit.sv
// Decode-stage immediate generator: one-cycle pipelined extension with a 2-entry
// skid buffer so the unit can accept one instruction per cycle under backpressure.
module cpu_imm_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [1:0]       occupancy
);

   typedef enum logic [2:0] {
      SrcI  = 3'd0,
      SrcS  = 3'd1,
      SrcB  = 3'd2,
      SrcU  = 3'd3,
      SrcJ  = 3'd4,
      SrcZ  = 3'd5,
      SrcSh = 3'd6,
      SrcRsv = 3'd7
   } imm_src_e;

   logic [31:0]      imm32;
   logic [XLEN-1:0]  imm_ext;
   logic             ill_ext;
   logic             unused_opcode;

   // Every format sign-extends cleanly from 32 bits: Z and SH are non-negative here.
   always_comb begin
      imm32   = '0;
      ill_ext = 1'b0;
      unique case (imm_src_e'(in_imm_src))
         SrcI:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         SrcS:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         SrcB:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
         SrcU:  imm32 = {in_instr[31:12], 12'b0};
         SrcJ:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
         SrcZ:  imm32 = {27'b0, in_instr[19:15]};
         SrcSh: begin
            if (XLEN == 64) begin
               imm32 = {26'b0, in_instr[25:20]};
            end else begin
               imm32   = {27'b0, in_instr[24:20]};
               ill_ext = in_instr[25];
            end
         end
         SrcRsv: begin
            imm32   = '0;
            ill_ext = 1'b1;
         end
         default: ;
      endcase
      imm_ext = XLEN'($signed(imm32));
   end

   assign unused_opcode = ^in_instr[6:0];

   logic             main_valid_q, main_valid_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d;
   logic             main_ill_q, main_ill_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             skid_ill_q, skid_ill_d;
   logic             accept, pop;

   assign in_ready    = !rst && !skid_valid_q;
   assign accept      = in_valid && in_ready;
   assign pop         = main_valid_q && out_ready;
   assign out_valid   = main_valid_q;
   assign out_imm     = main_imm_q;
   assign out_tag     = main_tag_q;
   assign out_illegal = main_ill_q;
   assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_tag_d   = main_tag_q;
      main_ill_d   = main_ill_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_tag_d   = skid_tag_q;
      skid_ill_d   = skid_ill_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || pop) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_tag_d   = skid_tag_q;
            main_ill_d   = skid_ill_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_imm_d   = imm_ext;
            main_tag_d   = in_tag;
            main_ill_d   = ill_ext;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = imm_ext;
         skid_tag_d   = in_tag;
         skid_ill_d   = ill_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_tag_q   <= '0;
         main_ill_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_tag_q   <= '0;
         skid_ill_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_tag_q   <= main_tag_d;
         main_ill_q   <= main_ill_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_tag_q   <= skid_tag_d;
         skid_ill_q   <= skid_ill_d;
      end
   end

endmodule

// File: tb/tb_cpu_imm_unit.sv
// Bench for cpu_imm_unit: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are checked every cycle against a queue-based reference plus literal vectors.
module tb_cpu_imm_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [2:0]  in_imm_src = '0;
   logic [7:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [7:0]  tag32, tag64;
   logic [1:0]  occ32, occ64;

   always #5 clk = ~clk;

   cpu_imm_unit #(.XLEN(32), .TAG_W(8)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov32),
      .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32),
      .occupancy(occ32)
   );

   cpu_imm_unit #(.XLEN(64), .TAG_W(8)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov64),
      .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64),
      .occupancy(occ64)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference extension straight from the format table; returns {illegal, imm64}.
   function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] s,
                                           input bit x64);
      logic [11:0] v12;
      logic [12:0] v13;
      logic [20:0] v21;
      logic [63:0] v;
      logic        il;
      v  = '0;
      il = 1'b0;
      case (s)
         3'd0: begin v12 = i[31:20]; v = {{52{v12[11]}}, v12}; end
         3'd1: begin v12 = {i[31:25], i[11:7]}; v = {{52{v12[11]}}, v12}; end
         3'd2: begin
            v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
            v = {{51{v13[12]}}, v13};
         end
         3'd3: v = {{32{i[31]}}, i[31:12], 12'b0};
         3'd4: begin
            v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
            v = {{43{v21[20]}}, v21};
         end
         3'd5: v = {59'b0, i[19:15]};
         3'd6: begin
            if (x64) v = {58'b0, i[25:20]};
            else begin v = {59'b0, i[24:20]}; il = i[25]; end
         end
         default: begin v = '0; il = 1'b1; end
      endcase
      return {il, v};
   endfunction

   typedef struct {
      logic [31:0] i32;
      logic [63:0] i64;
      logic        il32;
      logic        il64;
      logic [7:0]  tag;
   } ent_t;

   ent_t q[$];
   bit   chk_en = 0;
   bit   cleared = 1;

   always @(posedge clk) begin
      automatic bit   rdy_m = !rst && (q.size() < 2);
      automatic ent_t e;
      automatic logic [64:0] r32, r64;
      if (rst) begin
         q.delete();
         cleared = 1;
      end else if (flush) begin
         q.delete();
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy_m) begin
            r32 = ref_imm(in_instr, in_imm_src, 1'b0);
            r64 = ref_imm(in_instr, in_imm_src, 1'b1);
            e.i32 = r32[31:0];
            e.il32 = r32[64];
            e.i64 = r64[63:0];
            e.il64 = r64[64];
            e.tag = in_tag;
            q.push_back(e);
         end
      end
      if (q.size() > 0) cleared = 0;
      chk_en = 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready32", 64'(rdy32), 64'(!rst && q.size() < 2));
         chk("in_ready64", 64'(rdy64), 64'(!rst && q.size() < 2));
         chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
         chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
         chk("occupancy32", 64'(occ32), 64'(q.size()));
         chk("occupancy64", 64'(occ64), 64'(q.size()));
         if (q.size() > 0) begin
            chk("imm32", 64'(imm32), 64'(q[0].i32));
            chk("imm64", imm64, q[0].i64);
            chk("illegal32", 64'(ill32), 64'(q[0].il32));
            chk("illegal64", 64'(ill64), 64'(q[0].il64));
            chk("tag32", 64'(tag32), 64'(q[0].tag));
            chk("tag64", 64'(tag64), 64'(q[0].tag));
         end else if (cleared) begin
            chk("rst_imm32", 64'(imm32), 64'd0);
            chk("rst_imm64", imm64, 64'd0);
            chk("rst_tag", 64'({tag32, tag64}), 64'd0);
            chk("rst_ill", 64'({ill32, ill64}), 64'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush = 1'b0;
      for (int k = 0; k < n; k++) cyc();
   endtask

   // Single accept into an empty unit; results are visible right after return.
   task automatic send1(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
      in_valid = 1'b1;
      in_instr = i;
      in_imm_src = s;
      in_tag = t;
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic fill2(input logic [7:0] t0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_instr = $urandom;
         in_imm_src = 3'($urandom_range(0, 7));
         in_tag = t0 + 8'(k);
         cyc();
      end
   endtask

   logic [64:0] pin;

   initial begin
      int  nc;
      bit  acc;
      cyc();
      cyc();
      rst = 1'b0;
      idle(2);

      // Model pins against hand-derived values.
      pin = ref_imm(32'hFE000EE3, 3'd2, 1'b0);
      chk("pin_B", pin[63:0], 64'hFFFFFFFFFFFFFFFC);
      pin = ref_imm(32'h0010006F, 3'd4, 1'b1);
      chk("pin_J", pin[63:0], 64'h800);
      pin = ref_imm(32'h02800000, 3'd6, 1'b0);
      chk("pin_SH32", pin, {1'b1, 64'd8});

      send1(32'hFFF00093, 3'd0, 8'h11);
      chk("t1_valid", 64'(ov32), 64'd1);
      chk("t1_imm", 64'(imm32), 64'hFFFFFFFF);
      chk("t1_tag", 64'(tag32), 64'h11);
      chk("t1_ill", 64'(ill32), 64'd0);
      send1(32'hFE000EE3, 3'd2, 8'h12);
      chk("t2_B", 64'(imm32), 64'hFFFFFFFC);
      send1(32'h0010006F, 3'd4, 8'h13);
      chk("t2_J", 64'(imm32), 64'h00000800);
      send1(32'h000F8000, 3'd5, 8'h14);
      chk("t2_Z", 64'(imm32), 64'h1F);
      send1(32'h800000B7, 3'd3, 8'h15);
      chk("t3_U64", imm64, 64'hFFFFFFFF80000000);
      send1(32'h02800000, 3'd6, 8'h16);
      chk("t3_SH64", {63'd0, ill64} | (imm64 << 1), 64'd80);
      chk("t3_SH32", {ill32, imm32}, {1'b1, 32'd8});
      send1(32'hDEADBEEF, 3'd7, 8'h17);
      chk("t3_rsv", {ill64, imm64}, {1'b1, 64'd0});
      idle(2);

      // Backpressure: tags 1..4 offered back-to-back, downstream stalled for 3 cycles.
      out_ready = 1'b0;
      nc = 0;
      for (int t = 1; t <= 4; t++) begin
         in_valid = 1'b1;
         in_instr = $urandom;
         in_imm_src = 3'($urandom_range(0, 6));
         in_tag = 8'(t);
         acc = 0;
         while (!acc && nc < 20) begin
            acc = rdy32;
            cyc();
            nc++;
            if (nc == 2) begin
               chk("bp_occ_full", 64'(occ32), 64'd2);
               chk("bp_ready_low", 64'(rdy32), 64'd0);
            end
            if (nc == 3) out_ready = 1'b1;
         end
         if (!acc) chk("bp_accept_timeout", 64'd0, 64'd1);
      end
      idle(4);

      // Flush at full occupancy with a concurrent offer.
      fill2(8'h40);
      flush = 1'b1;
      in_tag = 8'hEE;
      cyc();
      chk("fl_valid", 64'(ov32), 64'd0);
      chk("fl_occ", 64'(occ32), 64'd0);
      chk("fl_ready", 64'(rdy32), 64'd1);
      idle(3);

      // Reset at full occupancy.
      fill2(8'h50);
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      chk("rs_state", {ov64, imm64, tag64, ill64, occ64}, '0);
      chk("rs_ready", 64'(rdy32), 64'd0);
      rst = 1'b0;
      #1;
      chk("rs_ready_after", 64'(rdy32), 64'd1);
      idle(2);

      for (int n = 0; n < 1500; n++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_instr = $urandom;
         in_imm_src = 3'($urandom_range(0, 7));
         in_tag = 8'($urandom);
         out_ready = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 99) < 3);
         rst = ($urandom_range(0, 99) < 2);
         cyc();
      end
      rst = 1'b0;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
